// File: rtl/serv_csr_ctrl_pkg.sv
// Shared constants for the CSR sequencer slice.
//   - CSR_SEL_*    : storage select codes driven on o_csr_sel
//   - CSR_SOURCE_* : write-source codes driven on o_csr_source
//   - CSR_ADDR_*   : architectural addresses of the implemented CSRs
//   - ILLEGAL_CAUSE: mcause value reported for an illegal CSR access
// The 0 codes (MTVEC / EXT) are also the idle value of the select and
// source outputs.
package serv_csr_ctrl_pkg;

  localparam logic [2:0] CSR_SEL_MTVEC    = 3'd0;
  localparam logic [2:0] CSR_SEL_MSCRATCH = 3'd1;
  localparam logic [2:0] CSR_SEL_MEPC     = 3'd2;
  localparam logic [2:0] CSR_SEL_MCAUSE   = 3'd3;
  localparam logic [2:0] CSR_SEL_MTVAL    = 3'd4;

  localparam logic [1:0] CSR_SOURCE_EXT = 2'd0;
  localparam logic [1:0] CSR_SOURCE_SET = 2'd1;
  localparam logic [1:0] CSR_SOURCE_CLR = 2'd2;
  localparam logic [1:0] CSR_SOURCE_CSR = 2'd3;

  localparam logic [11:0] CSR_ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_ADDR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_ADDR_MTVAL    = 12'h343;

  localparam logic [3:0] ILLEGAL_CAUSE = 4'd2;

endpackage

// File: rtl/serv_csr_ctrl_if.sv
// Request channel from the core decoder into the CSR sequencer.
//   csr_valid : a decoded Zicsr instruction is presented
//   csr_ready : sequencer can take it this cycle
//   csr_addr  : 12-bit CSR address
//   funct3    : Zicsr funct3
//   rs1_zero  : rs1/uimm field is zero
//   uimm      : immediate for the *I forms
// Handshake: a request transfers on a rising clock edge where csr_valid
// and csr_ready are both high. The master holds valid and the payload
// stable until that edge; ready may be asserted without valid and carries
// no obligation on its own.
interface serv_csr_ctrl_if;
  logic        csr_valid;
  logic        csr_ready;
  logic [11:0] csr_addr;
  logic [2:0]  funct3;
  logic        rs1_zero;
  logic [4:0]  uimm;

  modport master (
    output csr_valid, csr_addr, funct3, rs1_zero, uimm,
    input  csr_ready
  );

  modport slave (
    input  csr_valid, csr_addr, funct3, rs1_zero, uimm,
    output csr_ready
  );
endinterface

// File: rtl/serv_csr_decode.sv
// Combinational decode of a Zicsr request.
//   i_addr      : CSR address
//   i_funct3_lo : funct3[1:0] (operation; bit 2 only picks reg vs imm)
//   i_rs1_zero  : rs1/uimm field is zero
//   o_sel       : CSR_SEL_* of the addressed CSR
//   o_source    : CSR_SOURCE_* write source
//   o_illegal   : unimplemented address or funct3[1:0]==00
module serv_csr_decode
  import serv_csr_ctrl_pkg::*;
(
  input  logic [11:0] i_addr,
  input  logic [1:0]  i_funct3_lo,
  input  logic        i_rs1_zero,
  output logic [2:0]  o_sel,
  output logic [1:0]  o_source,
  output logic        o_illegal
);

  logic addr_ok;

  always_comb begin
    o_sel   = CSR_SEL_MTVEC;
    addr_ok = 1'b1;
    case (i_addr)
      CSR_ADDR_MTVEC:    o_sel = CSR_SEL_MTVEC;
      CSR_ADDR_MSCRATCH: o_sel = CSR_SEL_MSCRATCH;
      CSR_ADDR_MEPC:     o_sel = CSR_SEL_MEPC;
      CSR_ADDR_MCAUSE:   o_sel = CSR_SEL_MCAUSE;
      CSR_ADDR_MTVAL:    o_sel = CSR_SEL_MTVAL;
      default:           addr_ok = 1'b0;
    endcase
  end

  // Set/clear with a zero mask leaves the CSR untouched, so it is
  // issued as a plain read-back of the CSR itself.
  always_comb begin
    o_source = CSR_SOURCE_EXT;
    case (i_funct3_lo)
      2'b10:   o_source = i_rs1_zero ? CSR_SOURCE_CSR : CSR_SOURCE_SET;
      2'b11:   o_source = i_rs1_zero ? CSR_SOURCE_CSR : CSR_SOURCE_CLR;
      default: o_source = CSR_SOURCE_EXT;
    endcase
  end

  assign o_illegal = ~addr_ok | (i_funct3_lo == 2'b00);

endmodule

// File: rtl/serv_csr_ctrl.sv
// Bit-serial sequencer in front of the CSR storage block. Takes one Zicsr
// request (bus) or one trap request, then runs a 2**CNT_W-cycle LSB-first
// transfer and pulses o_done.
//   i_clk, i_rst_n         : clock, async active-low reset
//   bus (slave)            : request channel (valid/ready + payload)
//   i_rs1                  : serial rs1 bit aligned with o_cnt
//   i_trap_valid/_cause    : trap request (level) and its cause
//   o_en, o_csr_sel, o_csr_source, o_d, o_trap, o_mcause : to CSR storage
//   o_cnt                  : current bit index
//   o_rd_en, o_rd_zero     : serial rd writeback control
//   o_done                 : one-cycle completion pulse
//   o_dbg_state            : FSM state (0 IDLE, 1 XFER, 2 TRAP, 3 DONE)
// Build option SERV_CSR_ILLEGAL_TRAP_EN: when defined an illegal access
// takes the trap phase with mcause 2; otherwise it runs a transfer with
// the storage disabled and rd forced to zero.
module serv_csr_ctrl
  import serv_csr_ctrl_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  serv_csr_ctrl_if.slave    bus,
  input  logic              i_rs1,
  input  logic              i_trap_valid,
  input  logic [3:0]        i_trap_cause,
  output logic              o_en,
  output logic [2:0]        o_csr_sel,
  output logic [1:0]        o_csr_source,
  output logic              o_d,
  output logic              o_trap,
  output logic [3:0]        o_mcause,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_rd_en,
  output logic              o_rd_zero,
  output logic              o_done,
  output logic [1:0]        o_dbg_state
);

`ifdef SERV_CSR_ILLEGAL_TRAP_EN
  localparam bit ILL_TRAP_EN = 1'b1;
`else
  localparam bit ILL_TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TRAP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              imm_q;
  logic [4:0]        uimm_q;
  logic [2:0]        dec_sel;
  logic [1:0]        dec_source;
  logic              dec_illegal;
  logic              accept;
  logic [(1<<CNT_W)-1:0] uimm_ext;

  serv_csr_decode u_decode (
    .i_addr      (bus.csr_addr),
    .i_funct3_lo (bus.funct3[1:0]),
    .i_rs1_zero  (bus.rs1_zero),
    .o_sel       (dec_sel),
    .o_source    (dec_source),
    .o_illegal   (dec_illegal)
  );

  // A trap request masks ready, which gives it priority over a CSR request.
  assign bus.csr_ready = (state == IDLE) & ~i_trap_valid;
  assign accept        = bus.csr_valid & bus.csr_ready;

  assign o_cnt       = cnt;
  assign o_dbg_state = state;

  // Immediate forms shift out uimm zero-extended to the full word.
  assign uimm_ext = {{((1 << CNT_W) - 5){1'b0}}, uimm_q};
  assign o_d      = o_en & ~o_trap & (imm_q ? uimm_ext[cnt] : i_rs1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      imm_q        <= 1'b0;
      uimm_q       <= '0;
      o_en         <= 1'b0;
      o_csr_sel    <= CSR_SEL_MTVEC;
      o_csr_source <= CSR_SOURCE_EXT;
      o_trap       <= 1'b0;
      o_mcause     <= '0;
      o_rd_en      <= 1'b0;
      o_rd_zero    <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_trap_valid || (accept && dec_illegal && ILL_TRAP_EN)) begin
            state     <= TRAP;
            o_en      <= 1'b1;
            o_trap    <= 1'b1;
            o_csr_sel <= CSR_SEL_MEPC;
            o_mcause  <= i_trap_valid ? i_trap_cause : ILLEGAL_CAUSE;
          end else if (accept) begin
            // An illegal access that does not trap still walks the full
            // transfer so rd is written with zero and o_done keeps timing.
            state        <= XFER;
            o_en         <= ~dec_illegal;
            o_rd_en      <= 1'b1;
            o_rd_zero    <= dec_illegal;
            o_csr_sel    <= dec_sel;
            o_csr_source <= dec_source;
            imm_q        <= bus.funct3[2];
            uimm_q       <= bus.uimm;
          end
        end
        XFER, TRAP: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == '1) begin
            state        <= DONE;
            o_en         <= 1'b0;
            o_trap       <= 1'b0;
            o_rd_en      <= 1'b0;
            o_rd_zero    <= 1'b0;
            o_csr_sel    <= CSR_SEL_MTVEC;
            o_csr_source <= CSR_SOURCE_EXT;
            o_mcause     <= '0;
            o_done       <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_csr_ctrl.sv
module tb_serv_csr_ctrl;
  import serv_csr_ctrl_pkg::*;

`ifdef SERV_CSR_ILLEGAL_TRAP_EN
  localparam bit ILL_TRAP = 1'b1;
`else
  localparam bit ILL_TRAP = 1'b0;
`endif

  localparam int OW = 21;
  // Observation vector layout:
  // {en, rd_en, trap, sel[2:0], source[1:0], d, mcause[3:0], rd_zero, done, ready, cnt[4:0]}
  localparam logic [OW-1:0] FULL_MASK = 21'h1FFFFF;
  localparam logic [OW-1:0] ILL_MASK  = 21'h1C1FFF;  // sel/source don't-care
  localparam logic [OW-1:0] IDLE_VEC  = 21'h000020;  // only ready high
  localparam logic [OW-1:0] DONE_VEC  = 21'h000040;  // only done high

  // ---------------- clock / reset / DUT ----------------
  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_rs1;
  logic       i_trap_valid;
  logic [3:0] i_trap_cause;
  logic       o_en, o_d, o_trap, o_rd_en, o_rd_zero, o_done;
  logic [2:0] o_csr_sel;
  logic [1:0] o_csr_source;
  logic [3:0] o_mcause;
  logic [4:0] o_cnt;
  logic [1:0] o_dbg_state;

  always #5 i_clk = ~i_clk;

  serv_csr_ctrl_if bus ();

  serv_csr_ctrl #(.CNT_W(5)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .bus          (bus),
    .i_rs1        (i_rs1),
    .i_trap_valid (i_trap_valid),
    .i_trap_cause (i_trap_cause),
    .o_en         (o_en),
    .o_csr_sel    (o_csr_sel),
    .o_csr_source (o_csr_source),
    .o_d          (o_d),
    .o_trap       (o_trap),
    .o_mcause     (o_mcause),
    .o_cnt        (o_cnt),
    .o_rd_en      (o_rd_en),
    .o_rd_zero    (o_rd_zero),
    .o_done       (o_done),
    .o_dbg_state  (o_dbg_state)
  );

  logic [OW-1:0] obs;
  assign obs = {o_en, o_rd_en, o_trap, o_csr_sel, o_csr_source, o_d,
                o_mcause, o_rd_zero, o_done, bus.csr_ready, o_cnt};

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] msk_q[$];
  logic [OW-1:0] obs_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: address table, then the per-cycle picture of the
  // 32-bit transfer, the DONE cycle and the following IDLE cycle.
  function automatic int sel_of(input logic [11:0] a);
    case (a)
      12'h305: return int'(CSR_SEL_MTVEC);
      12'h340: return int'(CSR_SEL_MSCRATCH);
      12'h341: return int'(CSR_SEL_MEPC);
      12'h342: return int'(CSR_SEL_MCAUSE);
      12'h343: return int'(CSR_SEL_MTVAL);
      default: return -1;
    endcase
  endfunction

  task automatic model_push(input logic [11:0] a, input logic [2:0] f3,
                            input logic rz, input logic [4:0] uimm,
                            input logic [31:0] w, input bit is_trap,
                            input logic [3:0] cause);
    int s = sel_of(a);
    bit legal = (s >= 0) && (f3[1:0] != 2'b00);
    bit to_trap = is_trap || (!legal && ILL_TRAP);
    logic [31:0] imm_w = {27'b0, uimm};
    logic [1:0] src;
    logic en, rd, tr, d, rzo;
    logic [2:0] sl;
    logic [3:0] mc;
    logic [4:0] kk;
    if (f3[1:0] == 2'b01) src = CSR_SOURCE_EXT;
    else if (rz)          src = CSR_SOURCE_CSR;
    else if (f3[1:0] == 2'b10) src = CSR_SOURCE_SET;
    else                  src = CSR_SOURCE_CLR;
    for (int k = 0; k < 32; k++) begin
      kk = 5'(k);
      if (to_trap) begin
        en = 1; rd = 0; tr = 1; sl = CSR_SEL_MEPC; src = CSR_SOURCE_EXT;
        d = 0; mc = is_trap ? cause : 4'd2; rzo = 0;
      end else if (!legal) begin
        en = 0; rd = 1; tr = 0; sl = 3'd0; d = 0; mc = 4'd0; rzo = 1;
      end else begin
        en = 1; rd = 1; tr = 0; sl = s[2:0]; mc = 4'd0; rzo = 0;
        d = f3[2] ? imm_w[k] : w[k];
      end
      exp_q.push_back({en, rd, tr, sl, src, d, mc, rzo, 1'b0, 1'b0, kk});
      msk_q.push_back((!to_trap && !legal) ? ILL_MASK : FULL_MASK);
    end
    exp_q.push_back(DONE_VEC);
    msk_q.push_back(FULL_MASK);
    exp_q.push_back(IDLE_VEC);
    msk_q.push_back(FULL_MASK);
  endtask

  // ---------------- driver tasks ----------------
  // Present a CSR request and wait (bounded) for the accepting edge.
  task automatic drive_csr(input logic [11:0] a, input logic [2:0] f3,
                           input logic rz, input logic [4:0] uimm,
                           output bit ok, output int waited);
    bus.csr_valid = 1'b1;
    bus.csr_addr  = a;
    bus.funct3    = f3;
    bus.rs1_zero  = rz;
    bus.uimm      = uimm;
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (bus.csr_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      waited++;
      @(negedge i_clk);
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout addr=%h ready=%b required=1", a, bus.csr_ready);
      bus.csr_valid = 1'b0;
    end else begin
      @(posedge i_clk);
    end
  endtask

  task automatic drive_trap(input logic [3:0] cause);
    i_trap_valid = 1'b1;
    i_trap_cause = cause;
    @(posedge i_clk);
  endtask

  // Record n cycles starting just after the accepting edge, feeding the
  // serial rs1 word LSB first. Trap request is dropped in the DONE cycle.
  task automatic capture(input logic [31:0] w, input int n, input bit drop_valid);
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      if (drop_valid) bus.csr_valid = 1'b0;
      i_rs1 = (k < 32) ? w[k] : 1'b0;
      if (k == 32) i_trap_valid = 1'b0;
      #1;
      obs_q.push_back(obs);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    #1;
    n_cmp++;
    if (obs !== IDLE_VEC) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, IDLE_VEC);
    end
    i_trap_valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.csr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready_trap got=%b exp=0", bus.csr_ready);
    end
    i_trap_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    #1;
    n_cmp++;
    if (obs !== IDLE_VEC) begin
      n_err++;
      $display("FAIL post_reset_idle got=%h exp=%h", obs, IDLE_VEC);
    end
  endtask

  task automatic test_csrrw();
    bit ok; int wt, k;
    logic [OW-1:0] e, m, o;
    drive_csr(12'h340, 3'b001, 1'b0, 5'd0, ok, wt);
    if (ok) begin
      model_push(12'h340, 3'b001, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 4'd0);
      capture(32'hDEADBEEF, 34, 1'b1);
    end
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++;
      if ((o & m) !== (e & m)) begin
        n_err++;
        $display("FAIL csrrw k=%0d got=%h exp=%h", k, o & m, e & m);
      end
      k++;
    end
    obs_q.delete();
  endtask

  task automatic test_csrrsi();
    bit ok; int wt, k;
    logic [OW-1:0] e, m, o;
    logic [4:0] uv [2] = '{5'b10101, 5'b00000};
    for (int t = 0; t < 2; t++) begin
      drive_csr(12'h305, 3'b110, (uv[t] == 5'd0), uv[t], ok, wt);
      if (ok) begin
        model_push(12'h305, 3'b110, (uv[t] == 5'd0), uv[t], 32'hFFFFFFFF, 1'b0, 4'd0);
        capture(32'hFFFFFFFF, 34, 1'b1);
      end
      k = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); m = msk_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        n_cmp++;
        if ((o & m) !== (e & m)) begin
          n_err++;
          $display("FAIL csrrsi uimm=%b k=%0d got=%h exp=%h", uv[t], k, o & m, e & m);
        end
        k++;
      end
      obs_q.delete();
    end
  endtask

  task automatic test_trap_priority();
    bit ok; int wt, k;
    logic [OW-1:0] e, m, o;
    logic [31:0] w = $urandom;
    bus.csr_valid = 1'b1;
    bus.csr_addr  = 12'h341;
    bus.funct3    = 3'b001;
    bus.rs1_zero  = 1'b0;
    bus.uimm      = 5'd0;
    i_trap_valid  = 1'b1;
    i_trap_cause  = 4'hB;
    #1;
    n_cmp++;
    if (bus.csr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL trap_prio_ready got=%b exp=0", bus.csr_ready);
    end
    @(posedge i_clk);
    model_push(12'h000, 3'b000, 1'b0, 5'd0, 32'd0, 1'b1, 4'hB);
    capture(32'd0, 34, 1'b0);
    drive_csr(12'h341, 3'b001, 1'b0, 5'd0, ok, wt);
    n_cmp++;
    if (wt !== 0) begin
      n_err++;
      $display("FAIL trap_prio_followup_wait got=%0d exp=0", wt);
    end
    if (ok) begin
      model_push(12'h341, 3'b001, 1'b0, 5'd0, w, 1'b0, 4'd0);
      capture(w, 34, 1'b1);
    end
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++;
      if ((o & m) !== (e & m)) begin
        n_err++;
        $display("FAIL trap_prio k=%0d got=%h exp=%h", k, o & m, e & m);
      end
      k++;
    end
    obs_q.delete();
  endtask

  task automatic test_illegal();
    bit ok; int wt, k;
    logic [OW-1:0] e, m, o;
    logic [11:0] av [2] = '{12'h7C0, 12'h340};
    logic [2:0]  fv [2] = '{3'b001, 3'b000};
    for (int t = 0; t < 2; t++) begin
      drive_csr(av[t], fv[t], 1'b0, 5'd3, ok, wt);
      if (ok) begin
        model_push(av[t], fv[t], 1'b0, 5'd3, 32'hA5A5A5A5, 1'b0, 4'd0);
        capture(32'hA5A5A5A5, 34, 1'b1);
      end
      k = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); m = msk_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        n_cmp++;
        if ((o & m) !== (e & m)) begin
          n_err++;
          $display("FAIL illegal addr=%h k=%0d got=%h exp=%h", av[t], k, o & m, e & m);
        end
        k++;
      end
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int wt;
    drive_csr(12'h340, 3'b001, 1'b0, 5'd0, ok, wt);
    if (ok) capture(32'hFFFFFFFF, 17, 1'b1);
    obs_q.delete();
    @(negedge i_clk);
    #1;
    n_cmp++;
    if (o_cnt !== 5'd17) begin
      n_err++;
      $display("FAIL reset_mid_cnt got=%0d exp=17", o_cnt);
    end
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== IDLE_VEC) begin
      n_err++;
      $display("FAIL reset_mid_outputs got=%h exp=%h", obs, IDLE_VEC);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      #1;
      n_cmp++;
      if (o_done !== 1'b0 || bus.csr_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_mid_after c=%0d done=%b ready=%b exp done=0 ready=1",
                 c, o_done, bus.csr_ready);
      end
    end
  endtask

  task automatic test_random();
    bit ok; int wt, k;
    logic [OW-1:0] e, m, o;
    logic [11:0] legal_a [5] = '{12'h305, 12'h340, 12'h341, 12'h342, 12'h343};
    logic [11:0] a;
    logic [2:0] f3;
    logic [4:0] uimm;
    logic rz;
    logic [31:0] w;
    logic [3:0] cause;
    bit trap;
    for (int t = 0; t < 12; t++) begin
      a     = ($urandom_range(0, 5) == 5) ? (12'hB00 + 12'($urandom_range(0, 15)))
                                          : legal_a[$urandom_range(0, 4)];
      f3    = 3'($urandom_range(0, 7));
      uimm  = 5'($urandom_range(0, 31));
      rz    = f3[2] ? (uimm == 5'd0) : ($urandom_range(0, 3) == 0);
      w     = $urandom;
      cause = 4'($urandom_range(0, 15));
      trap  = ($urandom_range(0, 4) == 0);
      ok    = 1'b1;
      if (trap) drive_trap(cause);
      else drive_csr(a, f3, rz, uimm, ok, wt);
      if (ok) begin
        model_push(a, f3, rz, uimm, w, trap, cause);
        capture(w, 34, 1'b1);
      end
      k = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); m = msk_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        n_cmp++;
        if ((o & m) !== (e & m)) begin
          n_err++;
          $display("FAIL random t=%0d addr=%h f3=%b trap=%0d k=%0d got=%h exp=%h",
                   t, a, f3, trap, k, o & m, e & m);
        end
        k++;
      end
      obs_q.delete();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    i_rst_n       = 1'b0;
    i_rs1         = 1'b0;
    i_trap_valid  = 1'b0;
    i_trap_cause  = 4'd0;
    bus.csr_valid = 1'b0;
    bus.csr_addr  = 12'd0;
    bus.funct3    = 3'd0;
    bus.rs1_zero  = 1'b0;
    bus.uimm      = 5'd0;
    test_reset();
    test_csrrw();
    test_csrrsi();
    test_trap_priority();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serv_csr_ctrl.md
Name: serv_csr_ctrl

Overview:
- Bit-serial sequencer directly upstream of the CSR storage block.
- Accepts one decoded Zicsr instruction or one trap request and decodes the CSR address into a select and the funct3 into a source.
- Runs a 32-cycle LSB-first transfer, driving enable, select, source, trap, mcause and the serial write-data bit into the CSR storage block.
- Drives the serial rd-writeback enable; signals completion to the core state machine.

Parameters:
- CNT_W, 5, width of the bit counter; transfer length is 2**CNT_W cycles (32).

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_csr_valid  in  1  CSR instruction request
- o_csr_ready  out  1  request accepted this cycle when i_csr_valid is also high
- i_csr_addr  in  12  CSR address
- i_funct3  in  3  Zicsr funct3
- i_rs1_zero  in  1  rs1/uimm field is zero
- i_uimm  in  5  immediate for CSRRWI/CSRRSI/CSRRCI
- i_rs1  in  1  serial rs1 bit, aligned with o_cnt
- i_trap_valid  in  1  exception request; level, held until o_done
- i_trap_cause  in  4  exception cause
- o_en  out  1  CSR storage shift enable
- o_csr_sel  out  3  CSR_SEL_* code
- o_csr_source  out  2  CSR_SOURCE_* code
- o_d  out  1  serial write data to CSR storage
- o_trap  out  1  trap-capture phase
- o_mcause  out  4  cause presented during the trap phase
- o_cnt  out  CNT_W  current bit index
- o_rd_en  out  1  serial rd writeback enable
- o_rd_zero  out  1  force rd bit to 0
- o_done  out  1  one-cycle completion pulse

Behaviour:
- States and transitions:
  - IDLE -> XFER on an accepted CSR request.
  - IDLE -> TRAP on i_trap_valid, or on an accepted illegal request.
  - XFER -> DONE, and TRAP -> DONE, when cnt==31.
  - DONE -> IDLE unconditionally.
- Reset: asynchronous to IDLE; cnt=0; all outputs 0.
  - Exceptions: o_csr_ready=1 when i_trap_valid=0; o_csr_sel/o_csr_source hold 0 (CSR_SEL_MTVEC/CSR_SOURCE_EXT).
  - Reset during a transfer abandons it; no o_done.
- Ready and acceptance:
  - o_csr_ready = (state==IDLE) & ~i_trap_valid.
  - Trap has priority over a simultaneous CSR request; the request is not accepted that cycle.
  - Decoded sel, source, uimm and the illegal flag are registered at acceptance and held until DONE.
- Address decode:
  - 0x305 -> MTVEC; 0x340 -> MSCRATCH; 0x341 -> MEPC; 0x342 -> MCAUSE; 0x343 -> MTVAL.
  - Any other address, or funct3[1:0]==00, is illegal.
- Source decode:
  - funct3[1:0]=01 -> EXT.
  - 10 -> SET; 11 -> CLR.
  - SET or CLR with i_rs1_zero=1 -> CSR (read without modify).
- o_d:
  - funct3[2]=0: o_d = i_rs1.
  - funct3[2]=1: o_d = uimm[cnt] for cnt<5, else 0.
- XFER: exactly 32 cycles starting the cycle after acceptance.
  - o_en=1, o_rd_en=1, cnt runs 0..31.
  - cnt wraps to 0 on exit.
- TRAP: 32 cycles.
  - o_en=1, o_trap=1, o_rd_en=0, o_csr_sel=MEPC.
  - o_mcause = i_trap_cause captured on entry, or 2 for an illegal access; held constant for the whole phase.
- DONE: o_done=1 for one cycle; all other outputs as in IDLE.
  - Back-to-back requests are accepted no earlier than the IDLE cycle after DONE.
- i_trap_valid is ignored outside IDLE.
- Latency: acceptance to o_done is 33 cycles.

Optional Feature:
- Macro: SERV_CSR_ILLEGAL_TRAP_EN.
- Defined: an illegal access enters TRAP with mcause 2, and rd is not written.
- Undefined: an illegal access enters XFER with o_en=0, o_rd_en=1 and o_rd_zero=1. No CSR is modified, rd reads 0, and o_done is asserted normally.

Decomposition:
- CSR_SEL_*, CSR_SOURCE_*, CSR address constants and the illegal-instruction cause value (2) live in serv_params.vh.
- State encoding stays local.
- One sub-module is natural: serv_csr_decode, combinational address/funct3 -> {sel, source, illegal}.

Test Plan:
- CSRRW 0x340 with rs1 serial 0xDEADBEEF -> o_csr_ready pulse; 32 cycles o_en=o_rd_en=1, sel=MSCRATCH, source=EXT; o_d stream = 0xDEADBEEF LSB first; o_done exactly 33 cycles after acceptance.
- CSRRSI 0x305 with uimm=5'b10101 -> source=SET; o_d=1,0,1,0,1 then 27 zeros. Same with uimm=0 and i_rs1_zero=1 -> source=CSR.
- i_trap_valid=1, cause=4'hB, same cycle as i_csr_valid -> o_csr_ready=0; 32 cycles o_trap=1, o_mcause=0xB, o_rd_en=0; o_done pulse; the CSR request is accepted in the following IDLE.
- CSRRW 0x7C0, macro defined -> TRAP with o_mcause=2, no o_rd_en. Macro undefined -> o_en=0, o_rd_zero=1 for 32 cycles, o_done.
- Assert i_rst_n=0 at cnt=17 of XFER -> outputs 0 immediately; no o_done; o_csr_ready=1 after release.
